shift_l_arb: RTL and testbench

- Round-robin arbiter that shares one combinational shift_l_nbit left shifter among NUM_REQ requesters.
- Each requester presents an operand and a shift amount with a valid/ready handshake.
- The winning request is shifted and captured into a one-entry output register, tagged with the requester ID.
- Sits between the PIM command lanes and the shared shift resource.

---
 rtl/shift_l_pkg.sv | 20 ++
 rtl/rr_arb_nreq.sv | 26 ++
 rtl/shift_l_nbit.sv | 16 +
 rtl/shift_l_arb.sv | 107 ++++++++++
 tb/tb_shift_l_arb.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_l_pkg.sv
// Shared defaults and request/response types for the shift_l_arb shifter slice.
package shift_l_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_WIDTH       = 32;
  localparam int DEF_SHIFT_WIDTH = 5;
  localparam int DEF_ID_W        = $clog2(DEF_NUM_REQ);

  typedef struct packed {
    logic [DEF_WIDTH-1:0]       a;
    logic [DEF_SHIFT_WIDTH-1:0] b;
  } shift_req_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] y;
    logic [DEF_ID_W-1:0]  id;
    logic                 ovf;
  } shift_rsp_t;

endpackage

// File: rtl/rr_arb_nreq.sv
// Rotating-priority grant: first requester at or after ptr, scanning cyclically.
module rr_arb_nreq #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_l_nbit.sv
// Combinational logical left shifter; zero fill, result truncated to WIDTH.
module shift_l_nbit
  import shift_l_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [SHIFT_WIDTH-1:0] b,
  output logic [WIDTH-1:0]       y
);

  // Shift amounts >= WIDTH naturally produce all zeros.
  assign y = a << b;

endmodule

// File: rtl/shift_l_arb.sv
// Round-robin arbiter sharing one left shifter among NUM_REQ requesters.
// Define SHIFT_L_ARB_OVF_EN to add the registered rsp_ovf (bits shifted out) output.
module shift_l_arb
  import shift_l_pkg::*;
#(
  parameter  int NUM_REQ     = DEF_NUM_REQ,
  parameter  int WIDTH       = DEF_WIDTH,
  parameter  int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*SHIFT_WIDTH-1:0] req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WIDTH-1:0]             rsp_y,
  output logic [ID_W-1:0]              rsp_id
`ifdef SHIFT_L_ARB_OVF_EN
  , output logic                       rsp_ovf
`endif
);

  logic [ID_W-1:0]        ptr;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        g_idx;
  logic                   slot_free;
  logic                   accept;
  logic [WIDTH-1:0]       a_sel;
  logic [SHIFT_WIDTH-1:0] b_sel;
  logic [WIDTH-1:0]       y_shift;
  logic                   vld_p0;
  logic [WIDTH-1:0]       y_p0;
  logic [ID_W-1:0]        id_p0;

  rr_arb_nreq #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) g_idx = ID_W'(i);
    end
  end

  // rst_n gates ready so nothing is accepted while reset is held.
  assign slot_free = !vld_p0 || rsp_ready;
  assign req_ready = grant & {NUM_REQ{slot_free && rst_n}};
  assign accept    = |req_ready;

  assign a_sel = req_a[int'(g_idx)*WIDTH +: WIDTH];
  assign b_sel = req_b[int'(g_idx)*SHIFT_WIDTH +: SHIFT_WIDTH];

  shift_l_nbit #(.WIDTH(WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)) u_shift (
    .a (a_sel),
    .b (b_sel),
    .y (y_shift)
  );

`ifdef SHIFT_L_ARB_OVF_EN
  logic ovf_p0;

  function automatic logic ovf_of(input logic [WIDTH-1:0] a, input logic [SHIFT_WIDTH-1:0] b);
    int sh;
    sh = int'(b);
    if (sh == 0) return 1'b0;
    if (sh >= WIDTH) return |a;
    return |(a >> (WIDTH - sh));
  endfunction
`endif

  // Stage p0: one-entry result slot; an accept on a draining edge replaces the old result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      y_p0   <= '0;
      id_p0  <= '0;
      ptr    <= '0;
`ifdef SHIFT_L_ARB_OVF_EN
      ovf_p0 <= 1'b0;
`endif
    end else if (accept) begin
      vld_p0 <= 1'b1;
      y_p0   <= y_shift;
      id_p0  <= g_idx;
      ptr    <= (g_idx == ID_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
`ifdef SHIFT_L_ARB_OVF_EN
      ovf_p0 <= ovf_of(a_sel, b_sel);
`endif
    end else if (rsp_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign rsp_valid = vld_p0;
  assign rsp_y     = y_p0;
  assign rsp_id    = id_p0;
`ifdef SHIFT_L_ARB_OVF_EN
  assign rsp_ovf   = ovf_p0;
`endif

endmodule

// File: tb/tb_shift_l_arb.sv
// Self-checking bench for shift_l_arb: directed steps plus random traffic against a queue-free reference model.
module tb_shift_l_arb;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_a;
  logic [N*SW-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_y;
  logic [1:0]        rsp_id;
`ifdef SHIFT_L_ARB_OVF_EN
  logic              rsp_ovf;
`endif

  shift_l_arb #(.NUM_REQ(N), .WIDTH(W), .SHIFT_WIDTH(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id)
`ifdef SHIFT_L_ARB_OVF_EN
    , .rsp_ovf (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W-1:0]  a_in [N];
  logic [SW-1:0] b_in [N];

  // Reference model state
  bit            m_vld;
  logic [W-1:0]  m_y;
  int            m_id;
  int            m_ptr;
  bit            m_ovf;
  int            since3;
  int            last_g;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 1'b0; m_y = '0; m_id = 0; m_ptr = 0; m_ovf = 1'b0; since3 = 0; last_g = -1;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W]   = a_in[i];
      req_b[i*SW +: SW] = b_in[i];
    end
  endtask

  task automatic check_outputs();
    check("rsp_valid", 64'(rsp_valid), 64'(m_vld));
    check("rsp_y", 64'(rsp_y), 64'(m_y));
    check("rsp_id", 64'(rsp_id), 64'(m_id));
`ifdef SHIFT_L_ARB_OVF_EN
    check("rsp_ovf", 64'(rsp_ovf), 64'(m_ovf));
`endif
  endtask

  // One clock: called just after a falling edge with inputs set; returns on the next falling edge.
  task automatic cycle();
    int           g;
    bit           sf;
    logic [N-1:0] exp_rdy;
    logic [63:0]  wide;
    apply();
    #1;
    sf = !m_vld || rsp_ready;
    g  = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    exp_rdy = (sf && g >= 0) ? (4'(1) << g) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    if (exp_rdy != '0) begin
      wide   = 64'(a_in[g]) * (64'd2 ** b_in[g]);
      m_y    = wide[W-1:0];
      m_ovf  = (wide[63:W] != '0);
      m_id   = g;
      m_vld  = 1'b1;
      m_ptr  = (g + 1) % N;
      last_g = g;
      if (g == 3) since3 = 0;
      else if (req_valid[3]) since3++;
    end else if (rsp_ready) begin
      m_vld = 1'b0;
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    int exp_seq [5];
    logic [W-1:0] held_y;
    logic [1:0]   held_id;
    exp_seq = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin a_in[i] = '0; b_in[i] = '0; end
    apply();
    model_reset();
    #12;
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check_outputs();

    // Single request
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b0001; a_in[0] = 32'h0000_0001; b_in[0] = 5'd4; rsp_ready = 1'b1;
    cycle();
    check("single_y", 64'(rsp_y), 64'h10);
    check("single_id", 64'(rsp_id), 64'd0);
    req_valid = 4'b0000;
    cycle();

    // Round robin: park pointer at 0 via requester 3, then all four valid
    req_valid = 4'b1000; a_in[3] = $urandom; b_in[3] = 5'($urandom);
    cycle();
    req_valid = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < N; i++) begin a_in[i] = $urandom; b_in[i] = 5'($urandom); end
      cycle();
      check("rr_id", 64'(rsp_id), 64'(exp_seq[s]));
    end

    // Backpressure
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    held_y = rsp_y; held_id = rsp_id;
    for (int s = 0; s < 3; s++) begin
      cycle();
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_y_hold", 64'(rsp_y), 64'(held_y));
      check("bp_id_hold", 64'(rsp_id), 64'(held_id));
    end
    rsp_ready = 1'b1;
    cycle();
    check("bp_release_id", 64'(rsp_id), 64'd1);

    // Boundary shifts
    req_valid = 4'b0100; a_in[2] = 32'hFFFF_FFFF; b_in[2] = 5'd0;
    cycle();
    check("b0_y", 64'(rsp_y), 64'hFFFF_FFFF);
`ifdef SHIFT_L_ARB_OVF_EN
    check("b0_ovf", 64'(rsp_ovf), 64'd0);
`endif
    b_in[2] = 5'd31;
    cycle();
    check("b31_y", 64'(rsp_y), 64'h8000_0000);
`ifdef SHIFT_L_ARB_OVF_EN
    check("b31_ovf", 64'(rsp_ovf), 64'd1);
`endif

    // Async reset with a result pending and ptr=2
    req_valid = 4'b0010; a_in[1] = 32'h1234_5678; b_in[1] = 5'd3;
    cycle();
    rsp_ready = 1'b0; req_valid = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("areset_valid", 64'(rsp_valid), 64'd0);
    check("areset_y", 64'(rsp_y), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1010; rsp_ready = 1'b1;
    cycle();
    check("post_reset_id", 64'(rsp_id), 64'd1);

    // Starvation: requester 3 always valid, others random
    since3 = 0;
    for (int s = 0; s < 200; s++) begin
      req_valid = {1'b1, 3'($urandom)};
      rsp_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) begin a_in[i] = $urandom; b_in[i] = 5'($urandom); end
      cycle();
      check("starve3", 64'(since3 > 3), 64'd0);
    end

    // Fully random traffic
    for (int s = 0; s < 150; s++) begin
      req_valid = 4'($urandom);
      rsp_ready = ($urandom % 3) != 0;
      for (int i = 0; i < N; i++) begin a_in[i] = $urandom; b_in[i] = 5'($urandom); end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
